// File: rtl/relax_stage.sv
// relax_stage: serial Bellman-Ford relaxation over an internal 128-entry
// distance/predecessor table, fed by 4-lane edge batches.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   init, src_vtx           start table initialisation from source src_vtx
//   in_valid/in_ready       batch handshake
//   in_lane_valid           per-lane valid
//   in_dst                  lane k destination at [7k+6:7k]
//   in_edge                 lane k edge word {src[31:25], signed weight[24:0]}
//   pass_start              clears changed
//   changed                 some distance improved since pass_start/init
//   batch_done              one-cycle pulse when a batch finishes
//   busy                    high while initialising or relaxing
//   rd_addr/rd_dist/rd_pred registered table readout (1-cycle latency)
module relax_stage #(
  parameter int NUM_LANES = 4,
  parameter int VTX_W     = 7,
  parameter int DIST_W    = 25
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [VTX_W-1:0]              src_vtx,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES-1:0]          in_lane_valid,
  input  logic [NUM_LANES*VTX_W-1:0]    in_dst,
  input  logic [NUM_LANES*32-1:0]       in_edge,
  input  logic                          pass_start,
  output logic                          changed,
  output logic                          batch_done,
  output logic                          busy,
  input  logic [VTX_W-1:0]              rd_addr,
  output logic [DIST_W-1:0]             rd_dist,
  output logic [VTX_W-1:0]              rd_pred
);
  localparam int DEPTH = 1 << VTX_W;
  localparam int LW    = $clog2(NUM_LANES);
  localparam logic [DIST_W-1:0] INF     = {1'b0, {(DIST_W-1){1'b1}}};
  localparam logic [DIST_W-1:0] NEG_MAX = {1'b1, {(DIST_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, INIT, RELAX} state_t;

  state_t                               state;
  logic [VTX_W-1:0]                     ent_cnt;
  logic [LW-1:0]                        lane_cnt;
  logic [VTX_W-1:0]                     init_src;

  // captured batch
  logic [NUM_LANES-1:0]                 lv_q;
  logic [NUM_LANES-1:0][VTX_W-1:0]      src_q, dst_q;
  logic [NUM_LANES-1:0][DIST_W-1:0]     w_q;

  // unpacked lane inputs
  logic [NUM_LANES-1:0][VTX_W-1:0]      src_in, dst_in;
  logic [NUM_LANES-1:0][DIST_W-1:0]     w_in;

  logic [DIST_W-1:0]                    dist_mem [DEPTH];
  logic [VTX_W-1:0]                     pred_mem [DEPTH];

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign dst_in[k] = in_dst[k*VTX_W +: VTX_W];
      assign src_in[k] = in_edge[k*32 + 25 +: VTX_W];
      assign w_in[k]   = in_edge[k*32 +: DIST_W];
    end
  endgenerate

  assign in_ready = (state == IDLE) && !init;
  assign busy     = (state != IDLE);

  // Current lane datapath. Table reads are combinational so a write made by
  // the previous lane is already visible to this one.
  logic [VTX_W-1:0]  cur_src, cur_dst;
  logic [DIST_W-1:0] cur_w, d_src, d_dst, cand;
  logic [DIST_W:0]   sum;
  logic              improve;

  always_comb begin
    cur_src = src_q[lane_cnt];
    cur_dst = dst_q[lane_cnt];
    cur_w   = w_q[lane_cnt];
    d_src   = dist_mem[cur_src];
    d_dst   = dist_mem[cur_dst];
    sum     = {d_src[DIST_W-1], d_src} + {cur_w[DIST_W-1], cur_w};
    // top two bits disagree -> result left the 25-bit signed range
    if (sum[DIST_W] != sum[DIST_W-1])
      cand = sum[DIST_W] ? NEG_MAX : INF;
    else
      cand = sum[DIST_W-1:0];
    improve = (state == RELAX) && lv_q[lane_cnt] && (d_src != INF) &&
              ($signed(cand) < $signed(d_dst));
  end

  // Table is deliberately not reset; reset only suppresses writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        dist_mem[ent_cnt] <= (ent_cnt == init_src) ? '0 : INF;
        pred_mem[ent_cnt] <= (ent_cnt == init_src) ? init_src : '0;
      end else if (improve) begin
        dist_mem[cur_dst] <= cand;
        pred_mem[cur_dst] <= cur_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ent_cnt    <= '0;
      lane_cnt   <= '0;
      changed    <= 1'b0;
      batch_done <= 1'b0;
      rd_dist    <= '0;
      rd_pred    <= '0;
      lv_q       <= '0;
    end else begin
      batch_done <= 1'b0;
      rd_dist    <= dist_mem[rd_addr];
      rd_pred    <= pred_mem[rd_addr];

      // an improving write wins over a coincident clear
      if (improve)
        changed <= 1'b1;
      else if (pass_start || (state == IDLE && init))
        changed <= 1'b0;

      case (state)
        IDLE: begin
          if (init) begin
            state    <= INIT;
            init_src <= src_vtx;
            ent_cnt  <= '0;
          end else if (in_valid) begin
            state    <= RELAX;
            lane_cnt <= '0;
            lv_q     <= in_lane_valid;
            src_q    <= src_in;
            dst_q    <= dst_in;
            w_q      <= w_in;
          end
        end
        INIT: begin
          ent_cnt <= ent_cnt + 1'b1;
          if (ent_cnt == VTX_W'(DEPTH-1)) state <= IDLE;
        end
        RELAX: begin
          lane_cnt <= lane_cnt + 1'b1;
          if (lane_cnt == LW'(NUM_LANES-1)) begin
            state      <= IDLE;
            batch_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_relax_stage.sv
module tb_relax_stage;
  logic         clk = 1'b0;
  logic         reset, init, in_valid, pass_start;
  logic [6:0]   src_vtx, rd_addr;
  logic         in_ready, changed, batch_done, busy;
  logic [3:0]   in_lane_valid;
  logic [27:0]  in_dst;
  logic [127:0] in_edge;
  logic [24:0]  rd_dist;
  logic [6:0]   rd_pred;

  int n_chk = 0;
  int n_fail = 0;

  localparam int INF = 'h0FFFFFF;
  localparam int NEG = -16777216;

  relax_stage dut (
    .clk(clk), .reset(reset), .init(init), .src_vtx(src_vtx),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
    .in_dst(in_dst), .in_edge(in_edge), .pass_start(pass_start),
    .changed(changed), .batch_done(batch_done), .busy(busy),
    .rd_addr(rd_addr), .rd_dist(rd_dist), .rd_pred(rd_pred)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       ps;
    bit [3:0] lv;
    int       s[4];
    int       w[4];
    int       d[4];
    int       ca, da, pa, cb, db, pb;
    bit       ec;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int k, input int s, input int w, input int d);
    logic [6:0]  s7, d7;
    logic [24:0] w25;
    s7 = s[6:0]; d7 = d[6:0]; w25 = w[24:0];
    in_dst[7*k +: 7]   = d7;
    in_edge[32*k +: 32] = {s7, w25};
  endtask

  task automatic read_chk(input string nm, input int a, input int ed, input int ep);
    logic [24:0] e25;
    logic [6:0]  e7;
    e25 = ed[24:0]; e7 = ep[6:0];
    rd_addr = a[6:0];
    step();
    chk({nm, "_dist"}, {7'b0, rd_dist}, {7'b0, e25});
    chk({nm, "_pred"}, {25'b0, rd_pred}, {25'b0, e7});
  endtask

  task automatic do_init(input int s);
    int n;
    init = 1'b1; src_vtx = s[6:0];
    step();
    init = 1'b0;
    n = 0;
    while (busy && n < 300) begin n++; step(); end
    chk("init_busy_cycles", n, 128);
  endtask

  // Lanes and in_lane_valid must already be set. Handshake occurs at the
  // first edge; checks busy/in_ready/batch_done through t+6.
  task automatic send_batch(input bit ps_at1);
    bit ok;
    chk("ready_before_batch", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ok = 1'b1;
    pass_start = ps_at1;
    for (int k = 1; k <= 4; k++) begin
      if (!busy || batch_done || in_ready) ok = 1'b0;
      step();
      pass_start = 1'b0;
    end
    if (!batch_done || !in_ready || busy) ok = 1'b0;
    step();
    if (batch_done) ok = 1'b0;
    chk("batch_timing", {31'b0, ok}, 1);
  endtask

  initial begin
    // {ps, lv, src[0..3], w[0..3], dst[0..3], chkA addr/dist/pred, chkB, changed}
    vecs[0] = '{ps:0, lv:4'b0011, s:'{0,3,0,0}, w:'{10,-4,0,0}, d:'{3,7,0,0},
                ca:3, da:10, pa:0, cb:7, db:6, pb:3, ec:1};
    vecs[1] = '{ps:1, lv:4'b0001, s:'{5,0,0,0}, w:'{1,0,0,0}, d:'{9,0,0,0},
                ca:9, da:INF, pa:0, cb:5, db:INF, pb:0, ec:0};
    vecs[2] = '{ps:1, lv:4'b0000, s:'{0,0,0,0}, w:'{1,1,1,1}, d:'{9,9,9,9},
                ca:9, da:INF, pa:0, cb:0, db:0, pb:0, ec:0};
    vecs[3] = '{ps:1, lv:4'b1111, s:'{0,3,3,4}, w:'{20,-1,1,-20}, d:'{3,3,4,7},
                ca:4, da:10, pa:3, cb:3, db:9, pb:3, ec:1};
    vecs[4] = '{ps:1, lv:4'b0001, s:'{7,0,0,0}, w:'{5,0,0,0}, d:'{7,0,0,0},
                ca:7, da:-10, pa:4, cb:4, db:10, pb:3, ec:0};
    vecs[5] = '{ps:0, lv:4'b0010, s:'{0,7,0,0}, w:'{0,-3,0,0}, d:'{0,7,0,0},
                ca:7, da:-13, pa:7, cb:3, db:9, pb:3, ec:1};
    vecs[6] = '{ps:1, lv:4'b0011, s:'{0,2,0,0}, w:'{'h0FFFFF0,'hFF,0,0}, d:'{2,9,0,0},
                ca:9, da:INF, pa:0, cb:2, db:'h0FFFFF0, pb:0, ec:1};
    vecs[7] = '{ps:1, lv:4'b0011, s:'{0,10,0,0}, w:'{NEG,-5,0,0}, d:'{10,11,0,0},
                ca:11, da:NEG, pa:10, cb:10, db:NEG, pb:0, ec:1};

    reset = 1'b1; init = 1'b0; in_valid = 1'b0; pass_start = 1'b0;
    src_vtx = '0; rd_addr = '0; in_lane_valid = '0; in_dst = '0; in_edge = '0;
    step(); step();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_changed", {31'b0, changed}, 0);
    chk("rst_batch_done", {31'b0, batch_done}, 0);
    chk("rst_rd_dist", {7'b0, rd_dist}, 0);
    chk("rst_rd_pred", {25'b0, rd_pred}, 0);
    reset = 1'b0;
    step();

    // init from vertex 5
    do_init(5);
    chk("init5_changed", {31'b0, changed}, 0);
    read_chk("init5_v5", 5, 0, 5);
    read_chk("init5_v6", 6, INF, 0);

    // table-driven batches from source 0
    do_init(0);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ps) begin
        pass_start = 1'b1; step(); pass_start = 1'b0;
      end
      in_lane_valid = vecs[i].lv;
      for (int k = 0; k < 4; k++) set_lane(k, vecs[i].s[k], vecs[i].w[k], vecs[i].d[k]);
      send_batch(1'b0);
      chk($sformatf("v%0d_changed", i), {31'b0, changed}, {31'b0, vecs[i].ec});
      read_chk($sformatf("v%0d_a", i), vecs[i].ca, vecs[i].da, vecs[i].pa);
      read_chk($sformatf("v%0d_b", i), vecs[i].cb, vecs[i].db, vecs[i].pb);
    end

    // pass_start alone clears changed next cycle
    pass_start = 1'b1; step(); pass_start = 1'b0;
    chk("ps_alone_changed", {31'b0, changed}, 0);

    // pass_start coincident with an improving lane 0
    in_lane_valid = 4'b0001;
    set_lane(0, 0, 1, 40);
    send_batch(1'b1);
    chk("ps_coincide_changed", {31'b0, changed}, 1);
    read_chk("ps_coincide_v40", 40, 1, 0);

    // reset while lane 2 is processing
    pass_start = 1'b1; step(); pass_start = 1'b0;
    in_lane_valid = 4'b1111;
    set_lane(0, 0, 1, 20); set_lane(1, 20, 1, 21);
    set_lane(2, 21, 1, 22); set_lane(3, 22, 1, 23);
    in_valid = 1'b1; step(); in_valid = 1'b0;   // t+1: lane 0
    step();                                     // t+2: lane 1
    step();                                     // t+3: lane 2
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_changed", {31'b0, changed}, 0);
    step(); step();
    chk("mid_rst_no_done", {31'b0, batch_done}, 0);
    read_chk("mid_rst_v20", 20, 1, 0);
    read_chk("mid_rst_v21", 21, 2, 20);
    read_chk("mid_rst_v22", 22, INF, 0);
    read_chk("mid_rst_v23", 23, INF, 0);

    // init and in_valid together: INIT wins, no batch accepted
    in_lane_valid = 4'b0001;
    set_lane(0, 0, 1, 50);
    in_valid = 1'b1;
    init = 1'b1; src_vtx = 7'd0;
    #1;
    chk("init_blocks_ready", {31'b0, in_ready}, 0);
    step();
    in_valid = 1'b0; init = 1'b0;
    begin
      int n;
      n = 0;
      while (busy && n < 300) begin n++; step(); end
      chk("init_vs_valid_busy_cycles", n, 128);
    end
    chk("init_vs_valid_no_done", {31'b0, batch_done}, 0);
    read_chk("init_vs_valid_v50", 50, INF, 0);
    read_chk("init_vs_valid_v0", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
